// File: rtl/cache_2way_wb.sv
// Two-way set-associative write-back/write-allocate line cache with per-set LRU.
// CPU side is a valid/ready port; memory side transfers one whole line per req/ack.
module cache_2way_wb #(
    parameter int SETS       = 32,
    parameter int LINE_BYTES = 8,
    parameter int ADDR_L     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_L-1:0]       req_addr,
    input  logic [8*LINE_BYTES-1:0] req_wdata,
    input  logic [LINE_BYTES-1:0]   req_be,
    output logic                    resp_valid,
    output logic [8*LINE_BYTES-1:0] resp_rdata,
    output logic                    resp_hit,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_L-1:0]       mem_addr,
    output logic [8*LINE_BYTES-1:0] mem_wdata,
    input  logic                    mem_ack,
    input  logic [8*LINE_BYTES-1:0] mem_rdata
);
    localparam int IDX_L  = $clog2(SETS);
    localparam int OFS_L  = $clog2(LINE_BYTES);
    localparam int TAG_L  = ADDR_L - IDX_L - OFS_L;
    localparam int DATA_W = 8 * LINE_BYTES;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WB     = 3'd2,
        S_REFILL = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    function automatic logic [DATA_W-1:0] merge_line(
        input logic [DATA_W-1:0]     old_line,
        input logic [DATA_W-1:0]     new_data,
        input logic [LINE_BYTES-1:0] be
    );
        logic [DATA_W-1:0] res;
        res = old_line;
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_data[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_line[8*b +: 8];
            end
        end
        return res;
    endfunction

    state_t state_r, next_state_s;

    logic [TAG_L-1:0]          tag_mem  [2][SETS];
    logic [DATA_W-1:0]         data_mem [2][SETS];
    logic [1:0][SETS-1:0]      valid_r;
    logic [1:0][SETS-1:0]      dirty_r;
    logic [SETS-1:0]           lru_r;

    logic                      we_r;
    logic [TAG_L-1:0]          tag_r;
    logic [IDX_L-1:0]          idx_r;
    logic [DATA_W-1:0]         wdata_r;
    logic [LINE_BYTES-1:0]     be_r;
    logic                      victim_r;

    logic                      req_ready_r;
    logic                      resp_valid_r;
    logic                      resp_hit_r;
    logic [DATA_W-1:0]         resp_rdata_r;
    logic                      mem_req_r;
    logic                      mem_we_r;
    logic [ADDR_L-1:0]         mem_addr_r;
    logic [DATA_W-1:0]         mem_wdata_r;

    logic                      hit0_s, hit1_s, hit_s, hit_way_s;
    logic                      victim_s, victim_dirty_s, ack_s;
    logic [DATA_W-1:0]         hit_line_s, merged_s, fill_line_s;

    // Tag compare, victim choice and line merging for the latched request.
    always_comb begin
        hit0_s      = valid_r[0][idx_r] && (tag_mem[0][idx_r] == tag_r);
        hit1_s      = valid_r[1][idx_r] && (tag_mem[1][idx_r] == tag_r);
        hit_s       = hit0_s || hit1_s;
        hit_way_s   = hit1_s;
        hit_line_s  = data_mem[hit_way_s][idx_r];
        merged_s    = merge_line(hit_line_s, wdata_r, be_r);
        if (!valid_r[0][idx_r]) begin
            victim_s = 1'b0;
        end else if (!valid_r[1][idx_r]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[idx_r];
        end
        victim_dirty_s = valid_r[victim_s][idx_r] && dirty_r[victim_s][idx_r];
        // An ack only counts while a transfer is actually being requested.
        ack_s = mem_req_r && mem_ack;
        if (we_r) begin
            fill_line_s = merge_line(mem_rdata, wdata_r, be_r);
        end else begin
            fill_line_s = mem_rdata;
        end
    end

    // Next-state logic of the request sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid && req_ready_r) next_state_s = S_LOOKUP;
                else                          next_state_s = S_IDLE;
            end
            S_LOOKUP: begin
                if (hit_s)               next_state_s = S_IDLE;
                else if (victim_dirty_s) next_state_s = S_WB;
                else                     next_state_s = S_REFILL;
            end
            S_WB: begin
                if (ack_s) next_state_s = S_REFILL;
                else       next_state_s = S_WB;
            end
            S_REFILL: begin
                if (ack_s) next_state_s = S_RESP;
                else       next_state_s = S_REFILL;
            end
            S_RESP:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latch, status bits, memory port and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r      <= '0;
            dirty_r      <= '0;
            lru_r        <= '0;
            we_r         <= 1'b0;
            tag_r        <= '0;
            idx_r        <= '0;
            wdata_r      <= '0;
            be_r         <= '0;
            victim_r     <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_hit_r   <= 1'b0;
            resp_rdata_r <= '0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
        end else begin
            resp_valid_r <= 1'b0;
            req_ready_r  <= (next_state_s == S_IDLE);
            case (state_r)
                S_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        we_r    <= req_we;
                        tag_r   <= req_addr[ADDR_L-1 -: TAG_L];
                        idx_r   <= req_addr[OFS_L +: IDX_L];
                        wdata_r <= req_wdata;
                        be_r    <= req_be;
                    end
                end
                S_LOOKUP: begin
                    victim_r <= victim_s;
                    if (hit_s) begin
                        resp_valid_r <= 1'b1;
                        resp_hit_r   <= 1'b1;
                        resp_rdata_r <= we_r ? merged_s : hit_line_s;
                        lru_r[idx_r] <= ~hit_way_s;
                        if (we_r) dirty_r[hit_way_s][idx_r] <= 1'b1;
                    end else if (victim_dirty_s) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= {tag_mem[victim_s][idx_r], idx_r, {OFS_L{1'b0}}};
                        mem_wdata_r <= data_mem[victim_s][idx_r];
                    end else begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= {tag_r, idx_r, {OFS_L{1'b0}}};
                    end
                end
                S_WB: begin
                    if (ack_s) mem_req_r <= 1'b0;
                end
                S_REFILL: begin
                    // Entering from WB, mem_req is still low here: that is the idle gap cycle.
                    if (ack_s) begin
                        mem_req_r                <= 1'b0;
                        valid_r[victim_r][idx_r] <= 1'b1;
                        dirty_r[victim_r][idx_r] <= we_r;
                        lru_r[idx_r]             <= ~victim_r;
                        resp_rdata_r             <= fill_line_s;
                    end else if (!mem_req_r) begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= {tag_r, idx_r, {OFS_L{1'b0}}};
                    end
                end
                S_RESP: begin
                    resp_valid_r <= 1'b1;
                    resp_hit_r   <= 1'b0;
                end
                default: begin
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        if (state_r == S_LOOKUP && hit_s && we_r) begin
            data_mem[hit_way_s][idx_r] <= merged_s;
        end else if (state_r == S_REFILL && ack_s) begin
            data_mem[victim_r][idx_r] <= fill_line_s;
            tag_mem[victim_r][idx_r]  <= tag_r;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_hit   = resp_hit_r;
    assign resp_rdata = resp_rdata_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_cache_2way_wb.sv
// Directed self-checking bench for cache_2way_wb: hits, misses, write-back, LRU, reset.
module tb_cache_2way_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic        resp_valid, resp_hit;
    logic [63:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    // Observations from the last issued request.
    logic        obs_ready, busy_ready, obs_hit, unstable, gap_err;
    logic [63:0] obs_rdata;
    int          obs_cyc, n_xfer;
    logic        x_we    [4];
    logic [31:0] x_addr  [4];
    logic [63:0] x_wdata [4];

    localparam logic [63:0] F1 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] F2 = 64'h2121_2121_2121_2121;
    localparam logic [63:0] F4 = 64'h4141_4141_4141_4141;
    localparam logic [63:0] C1 = 64'h0101_0101_0101_0101;
    localparam logic [63:0] C2 = 64'h0202_0202_0202_0202;
    localparam logic [63:0] C3 = 64'h0303_0303_0303_0303;
    localparam logic [63:0] MERGED = 64'hA5A5_A5A5_3333_4444;

    cache_2way_wb dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Drive one request from a negedge and act as memory, acking each transfer after dly extra cycles.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [7:0] be, input logic [63:0] fill, input int dly);
        int   cnt;
        logic prev_req, acked;
        obs_ready = req_ready; busy_ready = 1'b1; obs_hit = 1'bx; obs_rdata = 'x;
        obs_cyc = 0; n_xfer = 0; unstable = 1'b0; gap_err = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        @(posedge clk);
        prev_req = 1'b0; acked = 1'b0; cnt = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            req_valid = 1'b0; req_we = ~we; req_addr = 32'hDEAD_BEE8;
            req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_be = 8'hFF; mem_ack = 1'b0;
            if (c == 1) busy_ready = req_ready;
            if (acked && mem_req) gap_err = 1'b1;
            acked = 1'b0;
            if (mem_req) begin
                if (!prev_req) begin
                    if (n_xfer < 4) begin
                        x_we[n_xfer] = mem_we; x_addr[n_xfer] = mem_addr; x_wdata[n_xfer] = mem_wdata;
                    end
                    n_xfer++;
                    cnt = 0;
                end else if (n_xfer <= 4 && (mem_we !== x_we[n_xfer-1] ||
                             mem_addr !== x_addr[n_xfer-1] || mem_wdata !== x_wdata[n_xfer-1])) begin
                    unstable = 1'b1;
                end
                cnt++;
                if (cnt > dly) begin
                    mem_ack = 1'b1; mem_rdata = fill; acked = 1'b1;
                end
            end
            prev_req = mem_req;
            if (resp_valid) begin
                obs_cyc = c; obs_hit = resp_hit; obs_rdata = resp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        checks++; if ({req_ready, resp_valid, resp_hit, mem_req, mem_we} !== 5'b10000) begin
            failures++; $display("FAIL reset_ctrl: got %b want 10000", {req_ready, resp_valid, resp_hit, mem_req, mem_we});
        end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 64'h0 || resp_rdata !== 64'h0) begin
            failures++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want zeros", mem_addr, mem_wdata, resp_rdata);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin
            failures++; $display("FAIL reset_idle: ready=%b mem_req=%b want 1 0", req_ready, mem_req);
        end
    endtask

    task automatic test_miss_refill();
        issue(1'b0, 32'h0000_0100, 64'h0, 8'h00, F1, 2);
        checks++; if (obs_hit !== 1'b0 || obs_rdata !== F1) begin
            failures++; $display("FAIL miss_resp: hit=%b rdata=%h want 0 %h", obs_hit, obs_rdata, F1);
        end
        checks++; if (n_xfer !== 1 || x_we[0] !== 1'b0 || x_addr[0] !== 32'h100) begin
            failures++; $display("FAIL miss_mem: n=%0d we=%b addr=%h want 1 0 100", n_xfer, x_we[0], x_addr[0]);
        end
        checks++; if (obs_cyc !== 6 || unstable !== 1'b0) begin
            failures++; $display("FAIL miss_latency: cyc=%0d unstable=%b want 6 0", obs_cyc, unstable);
        end
    endtask

    task automatic test_hit_load();
        issue(1'b0, 32'h0000_0100, 64'h0, 8'h00, 64'h0, 0);
        checks++; if (obs_cyc !== 2 || obs_hit !== 1'b1 || obs_rdata !== F1) begin
            failures++; $display("FAIL hit_load: cyc=%0d hit=%b rdata=%h want 2 1 %h", obs_cyc, obs_hit, obs_rdata, F1);
        end
        checks++; if (n_xfer !== 0 || busy_ready !== 1'b0 || obs_ready !== 1'b1) begin
            failures++; $display("FAIL hit_ctrl: xfers=%0d busy_ready=%b ready=%b want 0 0 1", n_xfer, busy_ready, obs_ready);
        end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin
            failures++; $display("FAIL resp_pulse: resp_valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_store_hit();
        issue(1'b1, 32'h0000_0100, 64'h1111_2222_3333_4444, 8'h0F, 64'h0, 0);
        checks++; if (obs_cyc !== 2 || obs_hit !== 1'b1 || obs_rdata !== MERGED || n_xfer !== 0) begin
            failures++; $display("FAIL store_hit: cyc=%0d hit=%b rdata=%h xfers=%0d want 2 1 %h 0", obs_cyc, obs_hit, obs_rdata, n_xfer, MERGED);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 32'h0000_0100, 64'h0, 8'h00, 64'h0, 0);
        issue(1'b0, 32'h0000_0104, 64'h0, 8'h00, 64'h0, 0);
        checks++; if (obs_ready !== 1'b1 || obs_cyc !== 2 || obs_rdata !== MERGED || obs_hit !== 1'b1) begin
            failures++; $display("FAIL back_to_back: ready=%b cyc=%0d rdata=%h hit=%b want 1 2 %h 1", obs_ready, obs_cyc, obs_rdata, obs_hit, MERGED);
        end
    endtask

    task automatic test_writeback();
        issue(1'b0, 32'h0000_2100, 64'h0, 8'h00, F2, 0);
        checks++; if (obs_hit !== 1'b0 || obs_rdata !== F2 || n_xfer !== 1 || x_we[0] !== 1'b0 || x_addr[0] !== 32'h2100) begin
            failures++; $display("FAIL second_way: hit=%b rdata=%h n=%0d we=%b addr=%h", obs_hit, obs_rdata, n_xfer, x_we[0], x_addr[0]);
        end
        issue(1'b1, 32'h0000_2100, 64'h9999_9999_9999_9999, 8'h00, 64'h0, 0);
        checks++; if (obs_hit !== 1'b1 || obs_rdata !== F2 || obs_cyc !== 2) begin
            failures++; $display("FAIL store_be0: hit=%b rdata=%h cyc=%0d want 1 %h 2", obs_hit, obs_rdata, obs_cyc, F2);
        end
        issue(1'b0, 32'h0000_4100, 64'h0, 8'h00, F4, 1);
        checks++; if (n_xfer !== 2 || x_we[0] !== 1'b1 || x_addr[0] !== 32'h100 || x_wdata[0] !== MERGED) begin
            failures++; $display("FAIL wb_victim: n=%0d we=%b addr=%h wdata=%h want 2 1 100 %h", n_xfer, x_we[0], x_addr[0], x_wdata[0], MERGED);
        end
        checks++; if (x_we[1] !== 1'b0 || x_addr[1] !== 32'h4100 || unstable !== 1'b0 || gap_err !== 1'b0) begin
            failures++; $display("FAIL wb_refill: we=%b addr=%h unstable=%b gap_err=%b want 0 4100 0 0", x_we[1], x_addr[1], unstable, gap_err);
        end
        checks++; if (obs_hit !== 1'b0 || obs_rdata !== F4 || obs_cyc !== 8) begin
            failures++; $display("FAIL wb_resp: hit=%b rdata=%h cyc=%0d want 0 %h 8", obs_hit, obs_rdata, obs_cyc, F4);
        end
        issue(1'b0, 32'h0000_0100, 64'h0, 8'h00, F1, 0);
        checks++; if (n_xfer !== 2 || x_we[0] !== 1'b1 || x_addr[0] !== 32'h2100 || x_wdata[0] !== F2 || obs_cyc !== 6) begin
            failures++; $display("FAIL wb_dirty_be0: n=%0d we=%b addr=%h wdata=%h cyc=%0d want 2 1 2100 %h 6", n_xfer, x_we[0], x_addr[0], x_wdata[0], obs_cyc, F2);
        end
    endtask

    task automatic test_clean_evict();
        issue(1'b0, 32'h0000_0108, 64'h0, 8'h00, C1, 0);
        issue(1'b0, 32'h0000_2108, 64'h0, 8'h00, C2, 0);
        issue(1'b0, 32'h0000_4108, 64'h0, 8'h00, C3, 0);
        checks++; if (n_xfer !== 1 || x_we[0] !== 1'b0 || x_addr[0] !== 32'h4108 || obs_cyc !== 4 || obs_rdata !== C3) begin
            failures++; $display("FAIL clean_evict: n=%0d we=%b addr=%h cyc=%0d rdata=%h want 1 0 4108 4 %h", n_xfer, x_we[0], x_addr[0], obs_cyc, obs_rdata, C3);
        end
        issue(1'b0, 32'h0000_2108, 64'h0, 8'h00, 64'h0, 0);
        checks++; if (obs_hit !== 1'b1 || obs_rdata !== C2 || n_xfer !== 0) begin
            failures++; $display("FAIL mru_kept: hit=%b rdata=%h n=%0d want 1 %h 0", obs_hit, obs_rdata, n_xfer, C2);
        end
        issue(1'b0, 32'h0000_0108, 64'h0, 8'h00, C1, 0);
        checks++; if (obs_hit !== 1'b0 || n_xfer !== 1 || x_we[0] !== 1'b0 || obs_rdata !== C1) begin
            failures++; $display("FAIL lru_evicted: hit=%b n=%0d we=%b rdata=%h want 0 1 0 %h", obs_hit, n_xfer, x_we[0], obs_rdata, C1);
        end
    endtask

    task automatic test_reset_mid_refill();
        logic seen;
        seen = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0300; req_be = 8'h00;
        @(posedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (seen !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h300) begin
            failures++; $display("FAIL refill_start: seen=%b we=%b addr=%h want 1 0 300", seen, mem_we, mem_addr);
        end
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++; $display("FAIL async_reset: mem_req=%b ready=%b resp_valid=%b want 0 1 0", mem_req, req_ready, resp_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'h0000_0100, 64'h0, 8'h00, F1, 0);
        checks++; if (obs_hit !== 1'b0 || n_xfer !== 1 || x_addr[0] !== 32'h100 || obs_cyc !== 4 || obs_rdata !== F1) begin
            failures++; $display("FAIL reload_miss: hit=%b n=%0d addr=%h cyc=%0d rdata=%h want 0 1 100 4 %h", obs_hit, n_xfer, x_addr[0], obs_cyc, obs_rdata, F1);
        end
    endtask

    initial begin
        test_reset();
        test_miss_refill();
        test_hit_load();
        test_store_hit();
        test_back_to_back();
        test_writeback();
        test_clean_evict();
        test_reset_mid_refill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
